// File: rtl/fifo_pkg.sv
// Shared defaults and helpers for the parameterised show-ahead FIFO.
package fifo_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_DEPTH = 4;

    // One extra bit above the storage index acts as the wrap bit that tells full from empty.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: one synchronous write port, one asynchronous read port, contents never reset.
module fifo_mem #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
)(
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/param_fifo.sv
// Single-clock show-ahead FIFO: wrap-bit pointers, registered occupancy, threshold flags
// and sticky overflow/underflow indicators.
module param_fifo
    import fifo_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int AF_LEVEL = DEPTH - 1,
    parameter int AE_LEVEL = 1
)(
    input  logic                     clk,
    input  logic                     rstN,
    input  logic                     clr,
    input  logic                     write_en,
    input  logic [WIDTH-1:0]         write_data,
    input  logic                     read_en,
    output logic [WIDTH-1:0]         read_data,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int              PW   = ptr_width(DEPTH);
    localparam int              AW   = PW - 1;
    localparam logic [PW-1:0]   ONE  = 1;
    localparam logic [PW-1:0]   AF_L = PW'(AF_LEVEL);
    localparam logic [PW-1:0]   AE_L = PW'(AE_LEVEL);

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             full_s, empty_s, wr_acc, rd_acc;
    logic [WIDTH-1:0] mem_rdata;

    assign empty_s = (wr_ptr_q == rd_ptr_q);
    assign full_s  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // A write at full is still taken when a read frees the head slot in the same cycle.
    assign wr_acc = write_en && (!full_s || read_en);
    assign rd_acc = read_en && !empty_s;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (clr) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (wr_acc) wr_ptr_d = wr_ptr_q + ONE;
            if (rd_acc) rd_ptr_d = rd_ptr_q + ONE;
            case ({wr_acc, rd_acc})
                2'b10:   count_d = count_q + ONE;
                2'b01:   count_d = count_q - ONE;
                default: count_d = count_q;
            endcase
            if (write_en && full_s && !read_en) overflow_d  = 1'b1;
            if (read_en && empty_s)             underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (wr_acc && !clr),
        .waddr (wr_ptr_q[AW-1:0]),
        .wdata (write_data),
        .raddr (rd_ptr_q[AW-1:0]),
        .rdata (mem_rdata)
    );

    // Storage is not reset, so mask the head word whenever nothing valid is stored.
    assign read_data    = empty_s ? '0 : mem_rdata;
    assign full         = full_s;
    assign empty        = empty_s;
    assign count        = count_q;
    assign almost_full  = (count_q >= AF_L);
    assign almost_empty = (count_q <= AE_L);
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule

// File: tb/tb_param_fifo.sv
// Directed bench for param_fifo (WIDTH=4, DEPTH=4) with a queue scoreboard and occupancy model.
module tb_param_fifo;

    logic       clk = 1'b0;
    logic       rstN = 1'b0;
    logic       clr = 1'b0;
    logic       write_en = 1'b0;
    logic [3:0] write_data = '0;
    logic       read_en = 1'b0;
    logic [3:0] read_data;
    logic       full, empty, almost_full, almost_empty;
    logic [2:0] count;
    logic       overflow, underflow;

    int         n_checks = 0;
    int         n_fail = 0;
    logic [3:0] sb_q[$];
    int         m_cnt = 0;
    logic       m_ovf = 1'b0;
    logic       m_unf = 1'b0;

    param_fifo #(.WIDTH(4), .DEPTH(4)) dut (
        .clk          (clk),
        .rstN         (rstN),
        .clr          (clr),
        .write_en     (write_en),
        .write_data   (write_data),
        .read_en      (read_en),
        .read_data    (read_data),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, ":count"}, 32'(count), 32'(m_cnt));
        chk({tag, ":full"}, 32'(full), 32'(m_cnt == 4));
        chk({tag, ":empty"}, 32'(empty), 32'(m_cnt == 0));
        chk({tag, ":almost_full"}, 32'(almost_full), 32'(m_cnt >= 3));
        chk({tag, ":almost_empty"}, 32'(almost_empty), 32'(m_cnt <= 1));
        chk({tag, ":overflow"}, 32'(overflow), 32'(m_ovf));
        chk({tag, ":underflow"}, 32'(underflow), 32'(m_unf));
        if (sb_q.size() > 0) chk({tag, ":head"}, 32'(read_data), 32'(sb_q[0]));
        else                 chk({tag, ":head_zero"}, 32'(read_data), 32'd0);
    endtask

    // One clock of stimulus; the model predicts acceptance from its own occupancy.
    task automatic cyc(input string tag, input logic we, input logic [3:0] wd, input logic re);
        logic full_e, empty_e, wacc, racc;
        write_en   = we;
        write_data = wd;
        read_en    = re;
        #1;
        full_e  = (m_cnt == 4);
        empty_e = (m_cnt == 0);
        racc    = re && !empty_e;
        wacc    = we && (!full_e || re);
        if (racc) chk({tag, ":pop"}, 32'(read_data), 32'(sb_q.pop_front()));
        if (we && full_e && !re) m_ovf = 1'b1;
        if (re && empty_e)       m_unf = 1'b1;
        if (wacc) sb_q.push_back(wd);
        m_cnt = m_cnt + int'(wacc) - int'(racc);
        @(posedge clk);
        #1;
        write_en = 1'b0;
        read_en  = 1'b0;
        check_state(tag);
    endtask

    task automatic flush(input string tag, input logic we, input logic [3:0] wd);
        clr        = 1'b1;
        write_en   = we;
        write_data = wd;
        @(posedge clk);
        #1;
        clr      = 1'b0;
        write_en = 1'b0;
        sb_q.delete();
        m_cnt = 0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
        check_state(tag);
    endtask

    initial begin
        #3;
        check_state("reset_hold");
        @(negedge clk);
        rstN = 1'b1;
        @(posedge clk);
        #1;
        check_state("post_reset");

        for (int i = 1; i <= 4; i++) cyc("fill", 1'b1, 4'(i), 1'b0);
        cyc("overflow_write", 1'b1, 4'd5, 1'b0);
        for (int i = 0; i < 4; i++) cyc("drain", 1'b0, 4'd0, 1'b1);
        cyc("underflow_read", 1'b0, 4'd0, 1'b1);

        cyc("wr_rd_at_empty", 1'b1, 4'd7, 1'b1);
        flush("flush_plain", 1'b0, 4'd0);

        cyc("wrap_pre", 1'b1, 4'hA, 1'b0);
        cyc("wrap_pre", 1'b1, 4'hB, 1'b0);
        for (int k = 0; k < 10; k++) cyc("wrap", 1'b1, 4'(k + 3), 1'b1);

        cyc("refill", 1'b1, 4'hC, 1'b0);
        cyc("refill", 1'b1, 4'hD, 1'b0);
        cyc("wr_rd_at_full", 1'b1, 4'hE, 1'b1);
        cyc("overflow_again", 1'b1, 4'hF, 1'b0);
        cyc("to_three", 1'b0, 4'd0, 1'b1);
        flush("flush_with_write", 1'b1, 4'h9);

        cyc("pre_reset", 1'b1, 4'h6, 1'b0);
        cyc("pre_reset", 1'b1, 4'h8, 1'b0);
        #2;
        rstN = 1'b0;
        sb_q.delete();
        m_cnt = 0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
        #1;
        check_state("async_reset");
        @(negedge clk);
        rstN = 1'b1;
        cyc("after_reset", 1'b1, 4'h3, 1'b0);
        cyc("after_reset", 1'b0, 4'd0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/param_fifo.md
PARAM_FIFO -- requirements
Module: param_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 4, data word width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 4, entry count; power of two, >=2.
REQ-003 SHALL have parameter AF_LEVEL, default DEPTH-1, count at or above which almost_full asserts.
REQ-004 SHALL have parameter AE_LEVEL, default 1, count at or below which almost_empty asserts.
REQ-005 SHALL have port: clk  input  1  single clock, rising-edge active.
REQ-006 SHALL have port: rstN  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port: clr  input  1  synchronous flush.
REQ-008 SHALL have port: write_en  input  1  write request.
REQ-009 SHALL have port: write_data  input  WIDTH  write word.
REQ-010 SHALL have port: read_en  input  1  read request (pop head).
REQ-011 SHALL have port: read_data  output  WIDTH  head word (show-ahead).
REQ-012 SHALL have ports: full, empty, almost_full, almost_empty  output  1 each  status flags.
REQ-013 SHALL have port: count  output  $clog2(DEPTH)+1  current occupancy.
REQ-014 SHALL have ports: overflow, underflow  output  1 each  sticky error flags.

Function
REQ-015 Pointers SHALL be $clog2(DEPTH)+1 bits; MSB is wrap bit; low bits index storage.
REQ-016 empty SHALL equal (wr_ptr == rd_ptr); full SHALL equal (MSBs differ, low bits equal).
REQ-017 Write accepted SHALL be write_en && (!full || read_en); accepted write stores write_data at wr_ptr, wr_ptr+1 next edge.
REQ-018 Read accepted SHALL be read_en && !empty; accepted read advances rd_ptr+1 next edge.
REQ-019 read_data SHALL be storage[rd_ptr] combinationally when !empty, else all zeros; no empty-bypass of write_data.
REQ-020 Simultaneous write+read at full SHALL accept both; count unchanged, full stays 1.
REQ-021 Simultaneous write+read at empty SHALL accept write only; count becomes 1; underflow set.
REQ-022 count SHALL be registered: +1 write-only, -1 read-only, unchanged both/neither; range 0..DEPTH.
REQ-023 almost_full SHALL be (count >= AF_LEVEL); almost_empty SHALL be (count <= AE_LEVEL); both combinational from count.
REQ-024 overflow SHALL set on write_en && full && !read_en; underflow SHALL set on read_en && empty; both hold until clr or reset.
REQ-025 Pointers SHALL wrap naturally modulo 2*DEPTH; no wrap SHALL corrupt data order.
REQ-026 clr SHALL, next edge, zero pointers, count, overflow, underflow; clr overrides write_en/read_en same cycle.
REQ-027 Stored data SHALL be first-in first-out; latency write-accept to visible on read_data: one cycle when empty.

Reset
REQ-028 rstN low SHALL immediately zero wr_ptr, rd_ptr, count, overflow, underflow.
REQ-029 During and after reset: empty=1, almost_empty=1, full=0, almost_full=0, count=0, read_data=0.
REQ-030 Storage array SHALL NOT be reset; reset mid-operation discards all contents.
REQ-031 Reset deassertion SHALL be followed by normal operation on next rising edge.

Structure
REQ-032 Package fifo_pkg SHALL hold default WIDTH/DEPTH constants and a function returning pointer width.
REQ-033 Storage SHALL be sub-module fifo_mem (1 write port, 1 async read port, no reset).
REQ-034 Pointer, count, flag, error logic SHALL live in param_fifo top.

Verification (WIDTH=4, DEPTH=4)
REQ-035 Fill: write 1,2,3,4 -> full=1 after 4th, count=4, almost_full=1 from count 3; 5th write 5 alone -> overflow=1, contents unchanged.
REQ-036 Drain: read 4 from full -> read_data 1,2,3,4 in order, empty=1, count=0; 5th read -> underflow=1.
REQ-037 Wrap: 10 cycles write k+read steady at count 2 -> ordering preserved across pointer wrap, count=2 throughout.
REQ-038 Edges: write+read at full -> count 4, both accepted; write+read at empty with 7 -> count 1, read_data=7 next cycle, underflow=1.
REQ-039 Flush: count 3, overflow=1, assert clr with write_en -> next cycle count 0, empty=1, overflow=0, write ignored.
REQ-040 Async reset: drop rstN mid-cycle at count 2 -> empty=1, count=0 before next edge.
